// File: rtl/alu_exec_unit.sv
// Registered execute stage: logic/arith ops complete in one cycle, shifts iterate one bit per cycle.
// Define ALU_FAST_SHIFT_EN to replace the iterative shifter with a single-cycle barrel shifter.
module alu_exec_unit #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       alu_op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic [SHW-1:0]   shamt,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] alu_out,
  output logic             zero,
  output logic             overflow
);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_SLL = 4'b1000;
  localparam logic [3:0] OP_SRL = 4'b1001;
  localparam logic [3:0] OP_SRA = 4'b1010;
  localparam logic [3:0] OP_NOR = 4'b1100;

`ifdef ALU_FAST_SHIFT_EN
  typedef enum logic {IDLE, DONE} state_t;
`else
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
`endif

  state_t state;

  function automatic logic is_shift(input logic [3:0] op);
    return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
  endfunction

`ifdef ALU_FAST_SHIFT_EN
  function automatic logic [WIDTH-1:0] barrel(input logic [3:0] op,
                                              input logic [WIDTH-1:0] v,
                                              input logic [SHW-1:0] sh);
    logic signed [WIDTH-1:0] sv;
    logic [WIDTH-1:0]        r;
    sv = v;
    case (op)
      OP_SLL:  r = v << sh;
      OP_SRL:  r = v >> sh;
      OP_SRA:  r = sv >>> sh;
      default: r = v;
    endcase
    return r;
  endfunction
`else
  function automatic logic [WIDTH-1:0] shift1(input logic [3:0] op,
                                              input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] r;
    case (op)
      OP_SLL:  r = {v[WIDTH-2:0], 1'b0};
      OP_SRL:  r = {1'b0, v[WIDTH-1:1]};
      OP_SRA:  r = {v[WIDTH-1], v[WIDTH-1:1]};
      default: r = v;
    endcase
    return r;
  endfunction
`endif

  // Single-cycle result; in the iterative build a shift only lands here when shamt is 0.
  function automatic logic [WIDTH-1:0] alu_result(input logic [3:0] op,
                                                  input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b,
                                                  input logic [SHW-1:0] sh);
    logic signed [WIDTH-1:0] sa;
    logic signed [WIDTH-1:0] sb;
    logic [WIDTH-1:0]        r;
    sa = a;
    sb = b;
    case (op)
      OP_AND: r = a & b;
      OP_OR:  r = a | b;
      OP_NOR: r = ~(a | b);
      OP_ADD: r = a + b;
      OP_SUB: r = a - b;
      OP_SLT: r = (sa < sb) ? WIDTH'(1) : '0;
`ifdef ALU_FAST_SHIFT_EN
      OP_SLL, OP_SRL, OP_SRA: r = barrel(op, b, sh);
`else
      OP_SLL, OP_SRL, OP_SRA: r = (sh == '0) ? b : '0;
`endif
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic logic signed_ovf(input logic [3:0] op,
                                      input logic [WIDTH-1:0] a,
                                      input logic [WIDTH-1:0] b,
                                      input logic [WIDTH-1:0] r);
    logic o;
    case (op)
      OP_ADD:  o = (a[WIDTH-1] == b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
      OP_SUB:  o = (a[WIDTH-1] != b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
      default: o = 1'b0;
    endcase
    return o;
  endfunction

  logic [WIDTH-1:0] imm_res;
  logic             imm_ovf;
  logic             go_iter;

  always_comb begin
    imm_res = alu_result(alu_op, src_a, src_b, shamt);
    imm_ovf = signed_ovf(alu_op, src_a, src_b, imm_res);
`ifdef ALU_FAST_SHIFT_EN
    go_iter = 1'b0;
`else
    go_iter = is_shift(alu_op) && (shamt != '0);
`endif
  end

`ifndef ALU_FAST_SHIFT_EN
  logic [WIDTH-1:0] work;
  logic [SHW-1:0]   cnt;
  logic [3:0]       sh_op;
  logic [WIDTH-1:0] work_nxt;

  always_comb work_nxt = shift1(sh_op, work);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      work  <= '0;
      cnt   <= '0;
      sh_op <= '0;
    end else if (state == IDLE && start && go_iter) begin
      work  <= src_b;
      cnt   <= shamt;
      sh_op <= alu_op;
    end else if (state == SHIFT) begin
      work <= work_nxt;
      cnt  <= cnt - 1'b1;
    end
  end
`endif

  // Control FSM; result/flag registers only change on the edge a result is produced.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      alu_out  <= '0;
      zero     <= 1'b1;
      overflow <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            busy <= 1'b1;
            if (go_iter) begin
`ifndef ALU_FAST_SHIFT_EN
              state <= SHIFT;
`endif
            end else begin
              alu_out  <= imm_res;
              zero     <= (imm_res == '0);
              overflow <= imm_ovf;
              done     <= 1'b1;
              state    <= DONE;
            end
          end
        end
`ifndef ALU_FAST_SHIFT_EN
        SHIFT: begin
          if (cnt == SHW'(1)) begin
            alu_out  <= work_nxt;
            zero     <= (work_nxt == '0);
            overflow <= 1'b0;
            done     <= 1'b1;
            state    <= DONE;
          end
        end
`endif
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed table-driven bench for alu_exec_unit (both shift builds via ALU_FAST_SHIFT_EN).
module tb_alu_exec_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  alu_op = '0;
  logic [31:0] src_a = '0;
  logic [31:0] src_b = '0;
  logic [4:0]  shamt = '0;
  logic        busy, done, zero, overflow;
  logic [31:0] alu_out;

  int checks = 0;
  int errors = 0;

  alu_exec_unit #(.WIDTH(32), .SHW(5)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .alu_op(alu_op),
    .src_a(src_a), .src_b(src_b), .shamt(shamt),
    .busy(busy), .done(done), .alu_out(alu_out), .zero(zero), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  sh;
    logic [31:0] exp_out;
    logic        exp_zero;
    logic        exp_ovf;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int exp_lat(input logic [3:0] op, input logic [4:0] sh);
    int l;
    l = 1;
`ifndef ALU_FAST_SHIFT_EN
    if ((op == 4'b1000 || op == 4'b1001 || op == 4'b1010) && sh != 0) l = int'(sh) + 1;
`endif
    return l;
  endfunction

  // Issue one op and return the number of edges (start edge included) until done is seen.
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] sh, output int lat);
    @(negedge clk);
    alu_op = op; src_a = a; src_b = b; shamt = sh; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1;
    while (!done && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!done) begin
      errors++;
      $display("FAIL timeout: done not seen within %0d cycles", lat);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    int lat;
    int first;
    int pulses;

    vecs[0]  = '{"or",        4'b0001, 32'h0000F0F0, 32'h00FF0000, 5'd0,  32'h00FFF0F0, 1'b0, 1'b0};
    vecs[1]  = '{"add_ovf",   4'b0010, 32'h7FFFFFFF, 32'h00000001, 5'd0,  32'h80000000, 1'b0, 1'b1};
    vecs[2]  = '{"sub_zero",  4'b0110, 32'h00000005, 32'h00000005, 5'd0,  32'h00000000, 1'b1, 1'b0};
    vecs[3]  = '{"and",       4'b0000, 32'hFF00FF00, 32'h0FF00FF0, 5'd0,  32'h0F000F00, 1'b0, 1'b0};
    vecs[4]  = '{"nor",       4'b1100, 32'h00000000, 32'h00000000, 5'd0,  32'hFFFFFFFF, 1'b0, 1'b0};
    vecs[5]  = '{"slt_true",  4'b0111, 32'hFFFFFFFF, 32'h00000001, 5'd0,  32'h00000001, 1'b0, 1'b0};
    vecs[6]  = '{"slt_false", 4'b0111, 32'h00000001, 32'hFFFFFFFF, 5'd0,  32'h00000000, 1'b1, 1'b0};
    vecs[7]  = '{"add_wrap",  4'b0010, 32'hFFFFFFFF, 32'h00000001, 5'd0,  32'h00000000, 1'b1, 1'b0};
    vecs[8]  = '{"bad_op",    4'b0011, 32'h00000005, 32'h00000005, 5'd0,  32'h00000000, 1'b1, 1'b0};
    vecs[9]  = '{"sll_sh0",   4'b1000, 32'h00000000, 32'h12345678, 5'd0,  32'h12345678, 1'b0, 1'b0};
    vecs[10] = '{"sub_ovf",   4'b0110, 32'h80000000, 32'h00000001, 5'd0,  32'h7FFFFFFF, 1'b0, 1'b1};
    vecs[11] = '{"sra4",      4'b1010, 32'h00000000, 32'h80000000, 5'd4,  32'hF8000000, 1'b0, 1'b0};
    vecs[12] = '{"srl31",     4'b1001, 32'h00000000, 32'hFFFFFFFF, 5'd31, 32'h00000001, 1'b0, 1'b0};
    vecs[13] = '{"sll3",      4'b1000, 32'h00000000, 32'h00000001, 5'd3,  32'h00000008, 1'b0, 1'b0};

    repeat (3) @(posedge clk);
    #1;
    check("rst_alu_out", alu_out, 32'h0);
    check("rst_zero", 32'(zero), 32'd1);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].sh, lat);
      check({vecs[i].name, "_out"}, alu_out, vecs[i].exp_out);
      check({vecs[i].name, "_zero"}, 32'(zero), 32'(vecs[i].exp_zero));
      check({vecs[i].name, "_ovf"}, 32'(overflow), 32'(vecs[i].exp_ovf));
      check({vecs[i].name, "_lat"}, lat, exp_lat(vecs[i].op, vecs[i].sh));
      check({vecs[i].name, "_idle"}, 32'(busy), 32'd0);
    end

    // SRA with a second start pulsed one cycle into the operation: must be ignored.
    @(negedge clk);
    alu_op = 4'b1010; src_a = '0; src_b = 32'h80000000; shamt = 5'd4; start = 1'b1;
    first = 0;
    pulses = 0;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (done) begin
        pulses++;
        if (first == 0) first = c;
      end
      if (c == 1) begin
        @(negedge clk);
        alu_op = 4'b0001; src_a = 32'hFFFFFFFF; src_b = 32'h0; shamt = '0; start = 1'b1;
      end
    end
    check("ign_first_done", first, exp_lat(4'b1010, 5'd4));
    check("ign_pulses", pulses, 1);
    check("ign_out", alu_out, 32'hF8000000);
    check("ign_busy", 32'(busy), 32'd0);

    // Reset asserted five cycles into a long SLL.
    @(negedge clk);
    alu_op = 4'b1000; src_a = '0; src_b = 32'h00000001; shamt = 5'd20; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_out", alu_out, 32'h0);
    check("mid_rst_zero", 32'(zero), 32'd1);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk); #1;
      if (done) pulses++;
    end
    check("post_rst_no_done", pulses, 0);

    run_op(4'b0001, 32'h0000000F, 32'hF0000000, 5'd0, lat);
    check("recover_out", alu_out, 32'hF000000F);
    check("recover_lat", lat, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Registered execute stage of the multi-cycle datapath.
- Consumes the bitwise OR/AND/NOR results of the per-bit gate slices and the adder output.
- Adds iterative shifts and latches the result into the ALUOut register consumed by the memory/writeback states.
- Driven by the main control FSM with a start/done handshake. Shifts take multiple cycles, so control waits on done.

Parameters:
- WIDTH, 32, operand and result width in bits.
- SHW, 5, shift-amount width; must satisfy 2^SHW >= WIDTH.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request an operation; accepted only in IDLE.
- alu_op  in  4  operation select; sampled at acceptance.
- src_a  in  WIDTH  operand A; sampled at acceptance.
- src_b  in  WIDTH  operand B, and the shift source for shifts; sampled at acceptance.
- shamt  in  SHW  shift amount; sampled at acceptance.
- busy  out  1  high while state != IDLE.
- done  out  1  one-cycle pulse when alu_out, zero and overflow are valid.
- alu_out  out  WIDTH  registered result (ALUOut).
- zero  out  1  registered flag: alu_out == 0.
- overflow  out  1  registered signed overflow; ADD and SUB only.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; alu_out=0, zero=1, overflow=0, busy=0, done=0.
  - Internal shift register and counter cleared.
  - Reset mid-shift aborts the operation; no done pulse is produced.
- alu_op encoding:
  - 0000 AND, 0001 OR, 1100 NOR.
  - 0010 ADD, 0110 SUB (two's complement, wrap modulo 2^WIDTH).
  - 0111 SLT: signed compare; result 1 if src_a < src_b, else 0.
  - 1000 SLL, 1001 SRL, 1010 SRA: shift src_b by shamt.
  - Any other code: result 0, overflow 0, completes as a single-cycle op.
- States: IDLE, SHIFT, DONE.
- IDLE, start=1, non-shift op:
  - Result, zero and overflow are written at that edge.
  - Go to DONE. done=1 the following cycle; latency 1.
- IDLE, start=1, shift op with shamt != 0:
  - Load work reg = src_b and count = shamt; go to SHIFT.
- IDLE, start=1, shift op with shamt = 0:
  - alu_out = src_b; go directly to DONE.
- SHIFT:
  - Each cycle, shift the work reg by 1 bit (SLL zero-fill, SRL zero-fill, SRA sign-fill) and decrement count.
  - When count reaches 1, the final shifted value is written to alu_out at that edge; go to DONE.
  - Shift latency = shamt + 1 cycles from the start edge to done.
- DONE: done=1 for exactly one cycle, then IDLE unconditionally.
- start while busy=1 (SHIFT or DONE) is ignored and not queued. Back-to-back ops therefore have a minimum spacing of 2 cycles.
- alu_out holds its value between operations. During SHIFT, alu_out keeps the previous result.
- overflow:
  - ADD: operands share a sign and the result sign differs.
  - SUB: operands differ in sign and the result sign differs from src_a.
  - Cleared for every other op.
- zero is computed from the value being written to alu_out, on the same edge.

Optional Feature:
- Macro: ALU_FAST_SHIFT_EN.
- Defined:
  - Shifts use a combinational barrel shifter and behave exactly like single-cycle ops (latency 1, no SHIFT state entered).
  - SHIFT state and counter are removed.
- Undefined: iterative shifting as described above.
- Result values are identical in both builds; only latency differs.

Test Plan:
- Reset:
  - Assert rst_n=0 mid-SHIFT (SLL, shamt=20, at cycle 5) -> alu_out=0, zero=1, busy=0 immediately (asynchronous); no done after release.
- OR:
  - start, alu_op=0001, src_a=0x0000F0F0, src_b=0x00FF0000 -> done next cycle; alu_out=0x00FFF0F0, zero=0, overflow=0.
- ADD/SUB overflow:
  - ADD 0x7FFFFFFF + 0x00000001 -> alu_out=0x80000000, overflow=1.
  - SUB 0x00000005 - 0x00000005 -> alu_out=0, zero=1, overflow=0.
- SRA:
  - SRA src_b=0x80000000, shamt=4 -> done exactly 5 cycles after start; alu_out=0xF8000000.
  - start pulsed again during SHIFT is ignored.
- Edges:
  - SLL shamt=0, src_b=0x12345678 -> done 1 cycle later, alu_out=0x12345678.
  - SRL shamt=31, src_b=0xFFFFFFFF -> done 32 cycles later, alu_out=0x00000001.
- SLT and fast build:
  - SLT src_a=0xFFFFFFFF (-1), src_b=0x00000001 -> alu_out=1.
  - With ALU_FAST_SHIFT_EN defined, SRL shamt=31 -> done after 1 cycle, alu_out=0x00000001.
